// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows a 32-bit register value to byte, half or word and
// stores it into a word-organised data memory without byte enables. Sub-word
// stores are done as read-modify-write. Busy stalls the pipeline while a store
// is in flight.
// Optional build macro: STORE_MISALIGN_TRAP_EN -- when defined, misaligned half
// or word stores complete immediately with Err=1 and make no memory access;
// when undefined, low address bits are forced to alignment.
module store_narrow_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Req,
  input  logic [1:0]            Size,
  input  logic [31:0]           Addr,
  input  logic [31:0]           WriteData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic                  MemRead,
  input  logic [31:0]           MemReadData,
  output logic                  MemWrite,
  output logic [31:0]           MemWriteData
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      state_r;
  logic [1:0]  size_r;
  logic [1:0]  lane_r;
  logic [31:0] wdata_r;
  logic        trap_s;
  logic        unused_s;

  // Upper byte-address bits lie beyond the memory and are deliberately dropped.
  assign unused_s = ^Addr[31:ADDR_WIDTH+2];

  // Little-endian merge of the narrowed store value into the word just read.
  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] data,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [31:0] res;
    res = old_word;
    case (size)
      2'b00: begin
        case (lane)
          2'b00:   res[7:0]   = data[7:0];
          2'b01:   res[15:8]  = data[7:0];
          2'b10:   res[23:16] = data[7:0];
          2'b11:   res[31:24] = data[7:0];
          default: res        = old_word;
        endcase
      end
      2'b01: begin
        if (lane[1]) begin
          res[31:16] = data[15:0];
        end else begin
          res[15:0] = data[15:0];
        end
      end
      default: res = data;
    endcase
    return res;
  endfunction

  // Decide whether the incoming request must be trapped as misaligned.
  always_comb begin
    trap_s = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
    case (Size)
      2'b01:   trap_s = Addr[0];
      2'b10:   trap_s = (Addr[1:0] != 2'b00);
      default: trap_s = 1'b0;
    endcase
`else
    trap_s = 1'b0;
`endif
  end

  // Store sequencer: accepts a request in IDLE and drives all registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r      <= ST_IDLE;
      size_r       <= 2'b00;
      lane_r       <= 2'b00;
      wdata_r      <= 32'h0000_0000;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Err          <= 1'b0;
      MemAddr      <= '0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      MemWriteData <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          Done <= 1'b0;
          Err  <= 1'b0;
          if (Req) begin
            size_r  <= Size;
            lane_r  <= Addr[1:0];
            wdata_r <= WriteData;
            MemAddr <= Addr[ADDR_WIDTH+1:2];
            Busy    <= 1'b1;
            if ((Size == 2'b11) || trap_s) begin
              // Reserved size or trapped misalignment: finish without memory access.
              state_r <= ST_DONE;
              Done    <= 1'b1;
              Err     <= 1'b1;
            end else if (Size == 2'b10) begin
              // Full word needs no merge, so skip the read.
              state_r      <= ST_WRITE;
              MemWrite     <= 1'b1;
              MemWriteData <= WriteData;
            end else begin
              state_r <= ST_READ;
              MemRead <= 1'b1;
            end
          end else begin
            Busy <= 1'b0;
          end
        end
        ST_READ: begin
          MemRead <= 1'b0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // Read data is valid now; merge straight into the write register.
          MemWriteData <= merge_word(MemReadData, wdata_r, size_r, lane_r);
          MemWrite     <= 1'b1;
          state_r      <= ST_WRITE;
        end
        ST_WRITE: begin
          MemWrite <= 1'b0;
          Done     <= 1'b1;
          Err      <= 1'b0;
          state_r  <= ST_DONE;
        end
        ST_DONE: begin
          Done    <= 1'b0;
          Err     <= 1'b0;
          Busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          MemRead  <= 1'b0;
          MemWrite <= 1'b0;
          Done     <= 1'b0;
          Err      <= 1'b0;
          Busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Testbench for store_narrow_unit: directed stores against a simple memory,
// with a schedule-based expectation model compared on every cycle.
module tb_store_narrow_unit;

  localparam int N = 1024;

  logic        Clk;
  logic        Rst_n;
  logic        Req;
  logic [1:0]  Size;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic [9:0]  MemAddr;
  logic        MemRead;
  logic [31:0] MemReadData;
  logic        MemWrite;
  logic [31:0] MemWriteData;

  store_narrow_unit #(.ADDR_WIDTH(10)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Size(Size), .Addr(Addr),
    .WriteData(WriteData), .Busy(Busy), .Done(Done), .Err(Err),
    .MemAddr(MemAddr), .MemRead(MemRead), .MemReadData(MemReadData),
    .MemWrite(MemWrite), .MemWriteData(MemWriteData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Data memory with synchronous read.
  logic [31:0] mem [0:N-1];
  logic [31:0] mem_rdata;
  logic [31:0] rnd_rdata;
  logic        rnd_sel;
  always @(posedge Clk) begin
    if (MemRead) mem_rdata <= mem[MemAddr];
    if (MemWrite) mem[MemAddr] <= MemWriteData;
  end
  assign MemReadData = rnd_sel ? rnd_rdata : mem_rdata;

  // Edge counter: index e means "outputs after rising edge e".
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Expected-output schedule.
  bit        exp_busy  [0:N-1];
  bit        exp_done  [0:N-1];
  bit        exp_err   [0:N-1];
  bit        exp_read  [0:N-1];
  bit        exp_write [0:N-1];
  bit [9:0]  exp_maddr [0:N-1];
  bit [31:0] exp_mwd   [0:N-1];
  bit [31:0] model_mem [0:N-1];
  bit        model_in_reset;
  int        undo_idx;
  int        undo_addr;
  bit [31:0] undo_val;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t cyc=%0d got=%h want=%h", nm, $time, cyc, act, exp);
    end
  endtask

  // Model: a request presented for rising edge k.
  task automatic model_accept(input int k, input logic [1:0] s, input logic [31:0] a,
                              input logic [31:0] d);
    int        wa;
    int        sh;
    bit        trap;
    bit [31:0] mask;
    bit [31:0] nv;
    if (model_in_reset || exp_busy[k-1]) return;
    wa = int'(a[11:2]);
    trap = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
    trap = (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
`endif
    for (int i = k; i < N; i++) exp_maddr[i] = a[11:2];
    if (s == 2'd3 || trap) begin
      exp_busy[k] = 1'b1;
      exp_done[k] = 1'b1;
      exp_err[k]  = 1'b1;
    end else if (s == 2'd2) begin
      exp_busy[k] = 1'b1; exp_busy[k+1] = 1'b1;
      exp_write[k] = 1'b1;
      exp_done[k+1] = 1'b1;
      for (int i = k; i < N; i++) exp_mwd[i] = d;
      undo_idx = k; undo_addr = wa; undo_val = model_mem[wa];
      model_mem[wa] = d;
    end else begin
      if (s == 2'd0) begin
        sh = 8 * int'(a[1:0]);
        mask = 32'h0000_00FF << sh;
        nv = (model_mem[wa] & ~mask) | ((d & 32'h0000_00FF) << sh);
      end else begin
        sh = 16 * int'(a[1]);
        mask = 32'h0000_FFFF << sh;
        nv = (model_mem[wa] & ~mask) | ((d & 32'h0000_FFFF) << sh);
      end
      for (int i = k; i < k + 4; i++) exp_busy[i] = 1'b1;
      exp_read[k] = 1'b1;
      exp_write[k+2] = 1'b1;
      exp_done[k+3] = 1'b1;
      for (int i = k + 2; i < N; i++) exp_mwd[i] = nv;
      undo_idx = k + 2; undo_addr = wa; undo_val = model_mem[wa];
      model_mem[wa] = nv;
    end
  endtask

  // Model: reset asserted during the cycle after edge e.
  task automatic model_reset(input int e);
    for (int i = e; i < N; i++) begin
      exp_busy[i] = 1'b0; exp_done[i] = 1'b0; exp_err[i] = 1'b0;
      exp_read[i] = 1'b0; exp_write[i] = 1'b0;
      exp_maddr[i] = 10'd0; exp_mwd[i] = 32'd0;
    end
    if (e <= undo_idx) model_mem[undo_addr] = undo_val;
  endtask

  // Per-cycle comparison of every output against the schedule.
  always @(negedge Clk) begin
    if (cyc < N) begin
      chk("Busy",         {31'd0, Busy},     {31'd0, exp_busy[cyc]});
      chk("Done",         {31'd0, Done},     {31'd0, exp_done[cyc]});
      chk("Err",          {31'd0, Err},      {31'd0, exp_err[cyc]});
      chk("MemRead",      {31'd0, MemRead},  {31'd0, exp_read[cyc]});
      chk("MemWrite",     {31'd0, MemWrite}, {31'd0, exp_write[cyc]});
      chk("MemAddr",      {22'd0, MemAddr},  {22'd0, exp_maddr[cyc]});
      chk("MemWriteData", MemWriteData,      exp_mwd[cyc]);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask

  // Hold a request for n edges; the model decides which edges accept it.
  task automatic req_cycles(input logic [1:0] s, input logic [31:0] a,
                            input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      Req = 1'b1; Size = s; Addr = a; WriteData = d;
      model_accept(cyc + 1, s, a, d);
      @(posedge Clk);
      #2;
    end
    Req = 1'b0;
  endtask

  initial begin
    undo_idx = -1; undo_addr = 0; undo_val = 32'd0;
    model_in_reset = 1'b1;
    Rst_n = 1'b0; rnd_sel = 1'b1; rnd_rdata = 32'd0;
    Req = 1'b0; Size = 2'd0; Addr = 32'd0; WriteData = 32'd0;

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      #2;
      Req = 1'($urandom); Size = 2'($urandom); Addr = $urandom;
      WriteData = $urandom; rnd_rdata = $urandom;
      @(posedge Clk);
    end
    #2;
    Req = 1'b0; rnd_sel = 1'b0;
    Rst_n = 1'b1; model_in_reset = 1'b0;
    idle(3);

    // Word store.
    req_cycles(2'd2, 32'h0000_0010, 32'hDEAD_BEEF, 1);
    idle(3);
    chk("mem4_word", mem[4], 32'hDEAD_BEEF);

    // Byte store at lane 3.
    req_cycles(2'd2, 32'h0000_0010, 32'h1122_3344, 1);
    idle(3);
    req_cycles(2'd0, 32'h0000_0013, 32'h1234_56AB, 1);
    idle(5);
    chk("mem4_byte", mem[4], 32'hAB22_3344);

    // Half store with a second request pulsed during WAIT.
    req_cycles(2'd2, 32'h0000_0020, 32'h1122_3344, 1);
    idle(3);
    req_cycles(2'd1, 32'h0000_0022, 32'hFFFF_CAFE, 1);
    idle(1);
    req_cycles(2'd2, 32'h0000_0040, 32'h0000_0000, 1);
    idle(4);
    chk("mem8_half", mem[8], 32'hCAFE_3344);

    // Misaligned half store.
    req_cycles(2'd2, 32'h0000_0020, 32'h1122_3344, 1);
    idle(3);
    req_cycles(2'd1, 32'h0000_0021, 32'hFFFF_CAFE, 1);
    idle(5);
`ifdef STORE_MISALIGN_TRAP_EN
    chk("mem8_misalign", mem[8], 32'h1122_3344);
`else
    chk("mem8_misalign", mem[8], 32'h1122_CAFE);
`endif

    // Reserved size.
    req_cycles(2'd3, 32'h0000_0030, 32'h0000_0000, 1);
    idle(3);

    // Request held high across DONE: second acceptance only after IDLE.
    req_cycles(2'd2, 32'h0000_0040, 32'hA5A5_0001, 4);
    idle(3);
    chk("mem16_held", mem[16], 32'hA5A5_0001);

    // Reset during WAIT of a byte store abandons it.
    req_cycles(2'd0, 32'h0000_0010, 32'h0000_0055, 1);
    idle(1);
    Rst_n = 1'b0; model_in_reset = 1'b1;
    model_reset(cyc);
    idle(2);
    Rst_n = 1'b1; model_in_reset = 1'b0;
    idle(1);
    chk("mem4_after_rst", mem[4], 32'hAB22_3344);
    req_cycles(2'd2, 32'h0000_0014, 32'h0BAD_F00D, 1);
    idle(3);
    chk("mem5_word", mem[5], 32'h0BAD_F00D);

    // Final memory image against the model.
    chk("final_mem4",  mem[4],  model_mem[4]);
    chk("final_mem5",  mem[5],  model_mem[5]);
    chk("final_mem8",  mem[8],  model_mem[8]);
    chk("final_mem16", mem[16], model_mem[16]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
